kbd_ascii_decoder: RTL and testbench

KBD_ASCII_DECODER -- requirements
Module: kbd_ascii_decoder

---
 rtl/kbd_pkg.sv | 42 ++++
 rtl/kbd_ascii_decoder_fifo.sv | 60 ++++++
 rtl/kbd_ascii_decoder.sv | 136 +++++++++++++
 tb/tb_kbd_ascii_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types, PS/2 set-2 scan constants and the scan-to-ASCII lookup for the
// keyboard decoder.
package kbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAKE,
    BRK,
    EXT,
    EXT_BRK
  } kbd_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  // Lower-case letters are folded to upper case by subtracting 0x20.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       upper);
    logic [7:0] c;
    case (code)
      8'h45: c = 8'h30;  8'h16: c = 8'h31;  8'h1E: c = 8'h32;  8'h26: c = 8'h33;
      8'h25: c = 8'h34;  8'h2E: c = 8'h35;  8'h36: c = 8'h36;  8'h3D: c = 8'h37;
      8'h3E: c = 8'h38;  8'h46: c = 8'h39;
      8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;  8'h23: c = 8'h64;
      8'h24: c = 8'h65;  8'h2B: c = 8'h66;  8'h34: c = 8'h67;  8'h33: c = 8'h68;
      8'h43: c = 8'h69;  8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;  8'h4D: c = 8'h70;
      8'h15: c = 8'h71;  8'h2D: c = 8'h72;  8'h1B: c = 8'h73;  8'h2C: c = 8'h74;
      8'h3C: c = 8'h75;  8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
      8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
      SC_SPACE: c = 8'h20;
      default: c = 8'h00;
    endcase
    if (upper && (c >= 8'h61) && (c <= 8'h7A)) c = c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/kbd_ascii_decoder_fifo.sv
// kbd_fifo: synchronous FIFO with registered head output, full/empty status and
// a sticky overflow flag for pushes dropped while full.
module kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count;
  logic          pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr + AW'(1);

  // NOTE: storage has no reset; only pointers, count and dout define visible state.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_next;
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
      if (push && full && !pop_ok) overflow <= 1'b1;
      if (pop_ok) begin
        if (count > (AW+1)'(1)) dout <= mem[rd_next];
        else if (push_ok)       dout <= din;
      end else if (push_ok && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 scan-code decoder: tracks make/break/extended sequences, shift state,
// and queues ASCII for printable keys. Optional caps lock: define KBD_CAPSLOCK_EN.
module kbd_ascii_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  input  logic             rd_en,
  output logic             key_down,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic [CNT_W-1:0] key_cnt,
  output logic [7:0]       fifo_dout,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow
);

  kbd_state_t state, state_nxt;
  logic       make_ev, brk_ev, ev_ext;
  logic [1:0] shift;
  logic       is_shift, is_mod, upper, push;
  logic [7:0] ascii_nxt;
`ifdef KBD_CAPSLOCK_EN
  logic caps;
  logic is_caps;
  assign is_caps = !ev_ext && (ps2_data == SC_CAPS);
  assign is_mod  = is_shift || is_caps;
  assign upper   = (|shift) ^ caps;
`else
  assign is_mod  = is_shift;
  assign upper   = |shift;
`endif

  assign is_shift  = !ev_ext && ((ps2_data == SC_LSHIFT) || (ps2_data == SC_RSHIFT));
  assign ascii_nxt = ev_ext ? 8'h00 : scan_to_ascii(ps2_data, upper);
  assign push      = make_ev && !is_mod && (ascii_nxt != 8'h00);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    ev_ext    = 1'b0;
    if (ps2_valid) begin
      unique case (state)
        IDLE, MAKE: begin
          if (ps2_data == SC_EXT)        state_nxt = EXT;
          else if (ps2_data == SC_BREAK) state_nxt = BRK;
          else begin
            state_nxt = MAKE;
            make_ev   = 1'b1;
          end
        end
        EXT: begin
          ev_ext = 1'b1;
          if (ps2_data == SC_BREAK) state_nxt = EXT_BRK;
          else begin
            state_nxt = MAKE;
            make_ev   = 1'b1;
          end
        end
        BRK: begin
          state_nxt = IDLE;
          brk_ev    = 1'b1;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          brk_ev    = 1'b1;
          ev_ext    = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= 2'b00;
      key_down  <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_ascii <= 8'h00;
      key_cnt   <= '0;
`ifdef KBD_CAPSLOCK_EN
      caps      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (make_ev) begin
        if (is_shift) begin
          if (ps2_data == SC_LSHIFT) shift[0] <= 1'b1;
          else                       shift[1] <= 1'b1;
`ifdef KBD_CAPSLOCK_EN
        end else if (is_caps) begin
          caps <= ~caps;
`endif
        end else begin
          key_code  <= ps2_data;
          key_ext   <= ev_ext;
          key_ascii <= ascii_nxt;
          key_down  <= 1'b1;
        end
      end
      if (brk_ev) begin
        if (is_shift) begin
          if (ps2_data == SC_LSHIFT) shift[0] <= 1'b0;
          else                       shift[1] <= 1'b0;
        end else if (!is_mod) begin
          key_cnt <= key_cnt + CNT_W'(1);
          if ((ps2_data == key_code) && (ev_ext == key_ext)) key_down <= 1'b0;
        end
      end
    end
  end

  kbd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (ascii_nxt),
    .pop      (rd_en),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// Self-checking bench for kbd_ascii_decoder: a byte-stream model with a queue FIFO,
// compared every cycle, plus literal expectations for the key scenarios.
module tb_kbd_ascii_decoder;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       ps2_data = 8'h00;
  logic             ps2_valid = 1'b0;
  logic             rd_en = 1'b0;
  logic             key_down, key_ext, fifo_empty, fifo_full, overflow;
  logic [7:0]       key_code, key_ascii, fifo_dout;
  logic [CNT_W-1:0] key_cnt;

  kbd_ascii_decoder #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid), .rd_en(rd_en),
    .key_down(key_down), .key_code(key_code), .key_ext(key_ext), .key_ascii(key_ascii),
    .key_cnt(key_cnt), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] letter_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                 8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                 8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};

  bit         m_ext_pfx, m_brk_pfx, m_lsh, m_rsh, m_caps, m_down, m_kext, m_ovf;
  logic [7:0] m_code, m_ascii, m_dout;
  int         m_cnt;
  logic [7:0] m_q[$];

  function automatic logic [7:0] model_ascii(input logic [7:0] sc, input bit up);
    for (int i = 0; i < 26; i++) if (letter_sc[i] == sc) return (up ? 8'd65 : 8'd97) + 8'(i);
    for (int i = 0; i < 10; i++) if (digit_sc[i] == sc) return 8'd48 + 8'(i);
    if (sc == 8'h29) return 8'h20;
    return 8'h00;
  endfunction

  function automatic bit caps_key(input logic [7:0] sc, input bit ext);
`ifdef KBD_CAPSLOCK_EN
    return !ext && sc == 8'h58;
`else
    return 1'b0;
`endif
  endfunction

  // Returns an ASCII byte to enqueue, or 0 for none.
  function automatic logic [7:0] model_make(input logic [7:0] sc, input bit ext);
    if (!ext && sc == 8'h12) begin m_lsh = 1; return 0; end
    if (!ext && sc == 8'h59) begin m_rsh = 1; return 0; end
    if (caps_key(sc, ext)) begin m_caps = !m_caps; return 0; end
    m_code  = sc;
    m_kext  = ext;
    m_ascii = ext ? 8'h00 : model_ascii(sc, (m_lsh || m_rsh) != m_caps);
    m_down  = 1;
    return m_ascii;
  endfunction

  function automatic void model_break(input logic [7:0] sc, input bit ext);
    if (!ext && sc == 8'h12) m_lsh = 0;
    else if (!ext && sc == 8'h59) m_rsh = 0;
    else if (!caps_key(sc, ext)) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (sc == m_code && ext == m_kext) m_down = 0;
    end
  endfunction

  function automatic void model_step(input bit r, input bit v, input logic [7:0] d, input bit rd);
    logic [7:0] pushv;
    int         pre;
    bit         pop_ok;
    if (r) begin
      {m_ext_pfx, m_brk_pfx, m_lsh, m_rsh, m_caps, m_down, m_kext, m_ovf} = '0;
      m_code = 0; m_ascii = 0; m_dout = 0; m_cnt = 0;
      m_q.delete();
      return;
    end
    pushv = 0;
    if (v) begin
      if (m_brk_pfx) begin
        model_break(d, m_ext_pfx);
        m_brk_pfx = 0; m_ext_pfx = 0;
      end else if (m_ext_pfx) begin
        if (d == 8'hF0) m_brk_pfx = 1;
        else begin pushv = model_make(d, 1); m_ext_pfx = 0; end
      end else if (d == 8'hE0) m_ext_pfx = 1;
      else if (d == 8'hF0) m_brk_pfx = 1;
      else pushv = model_make(d, 0);
    end
    pre    = m_q.size();
    pop_ok = rd && pre > 0;
    if (pop_ok) void'(m_q.pop_front());
    if (pushv != 0) begin
      if (pre == FIFO_DEPTH && !pop_ok) m_ovf = 1;
      else m_q.push_back(pushv);
    end
    if (m_q.size() > 0) m_dout = m_q[0];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("key_down",   key_down,   m_down);
      check("key_code",   key_code,   m_code);
      check("key_ext",    key_ext,    m_kext);
      check("key_ascii",  key_ascii,  m_ascii);
      check("key_cnt",    key_cnt,    m_cnt);
      check("fifo_empty", fifo_empty, m_q.size() == 0);
      check("fifo_full",  fifo_full,  m_q.size() == FIFO_DEPTH);
      check("overflow",   overflow,   m_ovf);
      check("fifo_dout",  fifo_dout,  m_dout);
    end
  end

  // ---------------- stimulus ----------------
  // One clock: drive at negedge, step the model at posedge, idle inputs at next negedge.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit rd);
    rst = r; ps2_valid = v; ps2_data = d; rd_en = rd;
    @(posedge clk);
    model_step(r, v, d, rd);
    @(negedge clk);
    rst = 0; ps2_valid = 0; ps2_data = 8'h00; rd_en = 0;
  endtask

  task automatic send(input logic [7:0] d); cycle(0, 1, d, 0); endtask
  task automatic do_reset();                cycle(1, 0, 8'h00, 0); endtask
  task automatic pop();                     cycle(0, 0, 8'h00, 1); endtask

  initial begin
    @(negedge clk);
    do_reset();
    cmp_en = 1;
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full",  fifo_full,  1'b0);
    check("rst_dout",  fifo_dout,  8'h00);
    check("rst_cnt",   key_cnt,    2'd0);

    // 'a' press and release
    send(8'h1C);
    check("a_ascii", key_ascii, 8'h61);
    check("a_down",  key_down,  1'b1);
    check("a_head",  fifo_dout, 8'h61);
    check("a_nempty", fifo_empty, 1'b0);
    send(8'hF0); send(8'h1C);
    check("a_up",  key_down, 1'b0);
    check("a_cnt", key_cnt,  2'd1);
    pop();
    check("a_drained", fifo_empty, 1'b1);

    // shifted 'A'; shift release not counted
    do_reset();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check("A_head", fifo_dout, 8'h41);
    check("A_cnt",  key_cnt,   2'd1);

    // extended key (keypad up)
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_code",  key_code,   8'h75);
    check("ext_flag",  key_ext,    1'b1);
    check("ext_ascii", key_ascii,  8'h00);
    check("ext_nopush", fifo_empty, 1'b1);
    check("ext_cnt",   key_cnt,    2'd1);

    // digits, space, unmapped, extended letter
    do_reset();
    send(8'h45); check("d0", key_ascii, 8'h30);
    send(8'h46); check("d9", key_ascii, 8'h39);
    send(8'h29); check("space", key_ascii, 8'h20);
    send(8'hE0); send(8'h1C); check("ext_a", key_ascii, 8'h00);
    send(8'h05); check("unmapped", key_ascii, 8'h00);
`ifndef KBD_CAPSLOCK_EN
    send(8'h58); check("caps_unmapped", key_code, 8'h58);
`endif

    // fill, overflow, push+pop while full, drain
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h16);
    check("full",     fifo_full, 1'b1);
    check("ovf",      overflow,  1'b1);
    cycle(0, 1, 8'h16, 1);
    check("pp_full",  fifo_full, 1'b1);
    check("pp_ovf",   overflow,  1'b1);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check("drain", fifo_dout, 8'h31);
      pop();
    end
    check("drained", fifo_empty, 1'b1);
    pop();
    check("empty_pop_hold", fifo_dout, 8'h31);

    // counter wrap, reset mid-break
    do_reset();
    for (int i = 0; i < 5; i++) begin send(8'h1C); send(8'hF0); send(8'h1C); end
    check("wrap_cnt", key_cnt, 2'd1);
    for (int i = 0; i < 5; i++) pop();
    send(8'hF0);
    do_reset();
    send(8'h1C);
    check("mid_rst_head", fifo_dout, 8'h61);
    check("mid_rst_down", key_down,  1'b1);
    check("mid_rst_cnt",  key_cnt,   2'd0);

`ifdef KBD_CAPSLOCK_EN
    do_reset();
    send(8'h58); send(8'h1C);
    check("caps_A", key_ascii, 8'h41);
    send(8'h12); send(8'h1C);
    check("caps_shift_a", key_ascii, 8'h61);
`endif

    @(negedge clk);
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
